clk_gate_ctrl: RTL and testbench

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

---
 rtl/clk_gate_ctrl.sv | 135 +++++++++++++
 tb/tb_clk_gate_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/clk_gate_ctrl.sv
// rtl/clk_gate_ctrl.sv - clock gate enable controller with wake delay, idle hysteresis and gate-off counter
//
// Purpose: drives the enable of a latch-based clock gate cell for a downstream
// domain. A requester raises req_i and waits for ack_o. After the requester
// releases the domain and busy_i clears, the enable stays up for IDLE_CYCLES
// more cycles before the clock is gated off.
//
// Ports:
//   clk_i      - block clock, rising edge
//   rst_i      - synchronous active-high reset
//   req_i      - requester wants the gated domain clocked
//   busy_i     - gated domain still has work in flight, holds the clock on
//   test_en_i  - DFT override, forces clk_en_o high
//   clk_en_o   - enable to the clock gate cell
//   ack_o      - gated clock stable, requester may proceed
//   gate_cnt_o - saturating count of completed gate-off events

module clk_gate_ctrl #(
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 4,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 busy_i,
    input  logic                 test_en_i,
    output logic                 clk_en_o,
    output logic                 ack_o,
    output logic [CNT_WIDTH-1:0] gate_cnt_o
);

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_WAKE  = 2'd1;
    localparam logic [1:0] ST_ON    = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Wide enough to hold WAKE_CYCLES, and at least one bit when it is 0.
    localparam int              WW        = $clog2(WAKE_CYCLES + 2);
    localparam logic [WW-1:0]   WAKE_LOAD = WW'(WAKE_CYCLES);
    localparam logic [WW-1:0]   WAKE_ONE  = WW'(1);
    localparam logic [7:0]      IDLE_LOAD = 8'(IDLE_CYCLES);
    localparam logic [7:0]      IDLE_ONE  = 8'd1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [1:0]           state_q, state_d;
    logic [WW-1:0]        wake_q, wake_d;
    logic [7:0]           idle_q, idle_d;
    logic                 en_q, en_d;
    logic                 ack_q, ack_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        wake_d  = wake_q;
        idle_d  = idle_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;

        case (state_q)
            ST_OFF: begin
                // busy_i is deliberately ignored here: only a request wakes the domain.
                if (req_i) begin
                    if (WAKE_CYCLES == 0) begin
                        state_d = ST_ON;
                    end else begin
                        state_d = ST_WAKE;
                        wake_d  = WAKE_LOAD;
                    end
                end
            end
            ST_WAKE: begin
                if (!req_i) begin
                    state_d = ST_DRAIN;
                    idle_d  = IDLE_LOAD;
                end else if (wake_q <= WAKE_ONE) begin
                    // ack is raised by the first ON cycle, giving one more stable cycle.
                    state_d = ST_ON;
                end else begin
                    wake_d = wake_q - WAKE_ONE;
                end
            end
            ST_ON: begin
                if (req_i) begin
                    ack_d = 1'b1;
                end else if (!busy_i) begin
                    state_d = ST_DRAIN;
                    idle_d  = IDLE_LOAD;
                end
            end
            default: begin // ST_DRAIN
                if (req_i) begin
                    // Clock never stopped, so no wake delay is needed.
                    state_d = ST_ON;
                    ack_d   = 1'b1;
                end else if (busy_i) begin
                    idle_d = IDLE_LOAD;
                end else if (idle_q <= IDLE_ONE) begin
                    state_d = ST_OFF;
                    if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    idle_d = idle_q - IDLE_ONE;
                end
            end
        endcase

        en_d = (state_d != ST_OFF);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_OFF;
            wake_q  <= '0;
            idle_q  <= '0;
            en_q    <= 1'b0;
            ack_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wake_q  <= wake_d;
            idle_q  <= idle_d;
            en_q    <= en_d;
            ack_q   <= ack_d;
            cnt_q   <= cnt_d;
        end
    end

    // The only combinational path: DFT override on top of the registered enable.
    assign clk_en_o   = en_q | test_en_i;
    assign ack_o      = ack_q;
    assign gate_cnt_o = cnt_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb/tb_clk_gate_ctrl.sv - directed self-checking bench for clk_gate_ctrl

module tb_clk_gate_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic       busy;
    logic       test_en;
    logic       clk_en, ack;
    logic [7:0] gate_cnt;
    logic       clk_en2, ack2;
    logic [1:0] gate_cnt2;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    clk_gate_ctrl dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .busy_i(busy), .test_en_i(test_en),
        .clk_en_o(clk_en), .ack_o(ack), .gate_cnt_o(gate_cnt)
    );

    clk_gate_ctrl #(.WAKE_CYCLES(0), .IDLE_CYCLES(4), .CNT_WIDTH(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .busy_i(busy), .test_en_i(test_en),
        .clk_en_o(clk_en2), .ack_o(ack2), .gate_cnt_o(gate_cnt2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; busy = 1'b0; test_en = 1'b0;
        step();
        rst = 1'b0;
        chk("rst_clk_en", {31'd0, clk_en}, 32'd0);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_cnt", {24'd0, gate_cnt}, 32'd0);
        chk("rst_cnt2", {30'd0, gate_cnt2}, 32'd0);

        // Wake: request at edge 0, enable after edge 0, ack after edge 3.
        req = 1'b1;
        step();
        chk("wake_e0_clk_en", {31'd0, clk_en}, 32'd1);
        chk("wake_e0_ack", {31'd0, ack}, 32'd0);
        step();
        chk("wake_e1_ack", {31'd0, ack}, 32'd0);
        step();
        chk("wake_e2_ack", {31'd0, ack}, 32'd0);
        step();
        chk("wake_e3_ack", {31'd0, ack}, 32'd1);
        step();
        step();

        // Gate-off: release sampled at edge d, ack drops at d, enable drops at d+4.
        req = 1'b0;
        step();
        chk("off_d_ack", {31'd0, ack}, 32'd0);
        chk("off_d_clk_en", {31'd0, clk_en}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("off_hold_clk_en", {31'd0, clk_en}, 32'd1);
        end
        step();
        chk("off_d4_clk_en", {31'd0, clk_en}, 32'd0);
        chk("off_cnt", {24'd0, gate_cnt}, 32'd1);

        // busy alone does not wake the domain.
        busy = 1'b1;
        step();
        step();
        chk("busy_in_off_clk_en", {31'd0, clk_en}, 32'd0);
        busy = 1'b0;

        // Hysteresis: re-request in DRAIN at idle count 2.
        req = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("hyst_wake_ack", {31'd0, ack}, 32'd1);
        req = 1'b0;
        step();
        chk("hyst_drain_ack", {31'd0, ack}, 32'd0);
        step();
        step();
        req = 1'b1;
        step();
        chk("hyst_reack", {31'd0, ack}, 32'd1);
        chk("hyst_clk_en", {31'd0, clk_en}, 32'd1);
        chk("hyst_cnt", {24'd0, gate_cnt}, 32'd1);

        // Busy hold: release with busy high for 6 cycles.
        req = 1'b0;
        busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("busy_hold_clk_en", {31'd0, clk_en}, 32'd1);
            chk("busy_hold_ack", {31'd0, ack}, 32'd0);
        end
        busy = 1'b0;
        step();
        chk("busy_drain_clk_en", {31'd0, clk_en}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("busy_drain_hold_clk_en", {31'd0, clk_en}, 32'd1);
        end
        step();
        chk("busy_drain_off_clk_en", {31'd0, clk_en}, 32'd0);
        chk("busy_drain_cnt", {24'd0, gate_cnt}, 32'd2);

        // DFT override in OFF.
        test_en = 1'b1;
        #1;
        chk("test_clk_en", {31'd0, clk_en}, 32'd1);
        chk("test_ack", {31'd0, ack}, 32'd0);
        step();
        chk("test_ack_after_edge", {31'd0, ack}, 32'd0);
        chk("test_cnt", {24'd0, gate_cnt}, 32'd2);
        test_en = 1'b0;
        #1;
        chk("test_release_clk_en", {31'd0, clk_en}, 32'd0);

        // Reset pulse while ON.
        req = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("pre_rst_ack", {31'd0, ack}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_on_ack", {31'd0, ack}, 32'd0);
        chk("rst_on_clk_en", {31'd0, clk_en}, 32'd0);
        chk("rst_on_cnt", {24'd0, gate_cnt}, 32'd0);
        step();
        chk("post_rst_req_clk_en", {31'd0, clk_en}, 32'd1);

        rst = 1'b1;
        req = 1'b0;
        step();
        rst = 1'b0;

        // Five full wake/gate-off cycles; dut2 has 2-bit counter and no wake delay.
        for (int i = 0; i < 5; i++) begin
            req = 1'b1;
            step();
            chk("sat_ack2_e0", {31'd0, ack2}, 32'd0);
            step();
            chk("sat_ack2_e1", {31'd0, ack2}, 32'd1);
            chk("sat_ack_e1", {31'd0, ack}, 32'd0);
            step();
            step();
            chk("sat_ack_e3", {31'd0, ack}, 32'd1);
            req = 1'b0;
            for (int j = 0; j < 5; j++) step();
            chk("sat_clk_en", {31'd0, clk_en}, 32'd0);
            chk("sat_clk_en2", {31'd0, clk_en2}, 32'd0);
            chk("sat_cnt", {24'd0, gate_cnt}, 32'(i + 1));
            chk("sat_cnt2", {30'd0, gate_cnt2}, (i + 1 > 3) ? 32'd3 : 32'(i + 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
